ma_stage: RTL and testbench

Memory-access stage of the 5-stage RISC-32 pipeline, between EX and WB. Accepts one instruction at a time from the EX/MA latch and performs the data-memory load or store over a variable-latency req/ack interface. Presents the registered MA/WB latch (IsWb, IsCall, IsLd, Rd, AluResult1, LdResult, pc_current) directly to the write-back stage. Stalls EX while a memory access is outstanding and retires hung accesses via a timeout.

---
 rtl/risc_pkg.sv | 14 +
 rtl/ma_mem_fsm.sv | 65 ++++++
 rtl/ma_stage.sv | 115 +++++++++++
 tb/tb_ma_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC-32 pipeline definitions: datapath widths, the link register
// index, and the memory-access stage FSM encoding.
package risc_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_RA = 4'd15;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } ma_state_t;

endpackage

// File: rtl/ma_mem_fsm.sv
// Memory-access handshake controller: tracks one outstanding req/ack access,
// abandons it after TIMEOUT cycles, and strobes retire/timeout to the datapath.
module ma_mem_fsm
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic mem_op,
  input  logic mem_ack,
  output logic ready,
  output logic accept,
  output logic retire,
  output logic timeout,
  output logic mem_req,
  output logic mem_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  ma_state_t     state;
  logic [CW-1:0] cnt;

  assign ready   = (state == S_IDLE);
  assign accept  = ready & in_valid;
  // An ack in the final WAIT cycle beats the timeout.
  assign timeout = (state == S_WAIT) & ~mem_ack & (cnt == LAST);
  assign retire  = (accept & ~mem_op) | ((state == S_WAIT) & (mem_ack | timeout));

  // NOTE: reset is sampled on the clock edge only, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_req <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && mem_op) begin
            state   <= S_WAIT;
            cnt     <= '0;
            mem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ack || timeout) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_err <= timeout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ma_stage.sv
// MA stage of the RISC-32 pipeline: captures the EX/MA latch, runs the data
// memory access, and presents the registered MA/WB latch to write-back.
module ma_stage
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_is_ld,
  input  logic             in_is_st,
  input  logic             in_is_wb,
  input  logic             in_is_call,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             mem_err,
  output logic             IsWb,
  output logic             IsCall,
  output logic             IsLd,
  output logic [REG_W-1:0] Rd,
  output logic [XLEN-1:0]  AluResult1,
  output logic [XLEN-1:0]  LdResult,
  output logic [XLEN-1:0]  pc_current
);

  logic mem_op, accept, retire, timeout;

  logic [XLEN-1:0]  cap_pc, cap_alu;
  logic [REG_W-1:0] cap_rd;
  logic             cap_wb, cap_call, cap_ld;

  assign mem_op = in_is_ld | in_is_st;

  ma_mem_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .mem_op   (mem_op),
    .mem_ack  (mem_ack),
    .ready    (in_ready),
    .accept   (accept),
    .retire   (retire),
    .timeout  (timeout),
    .mem_req  (mem_req),
    .mem_err  (mem_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_pc     <= '0;
      cap_alu    <= '0;
      cap_rd     <= '0;
      cap_wb     <= 1'b0;
      cap_call   <= 1'b0;
      cap_ld     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      IsWb       <= 1'b0;
      IsCall     <= 1'b0;
      IsLd       <= 1'b0;
      Rd         <= '0;
      AluResult1 <= '0;
      LdResult   <= '0;
      pc_current <= '0;
    end else begin
      // WB must see IsWb only in the single cycle following a retire.
      IsWb <= 1'b0;

      if (accept && mem_op) begin
        cap_pc    <= in_pc;
        cap_alu   <= in_alu;
        cap_rd    <= in_rd;
        cap_wb    <= in_is_wb;
        cap_call  <= in_is_call;
        cap_ld    <= in_is_ld;
        mem_we    <= in_is_st & ~in_is_ld;
        mem_addr  <= {in_alu[XLEN-1:2], 2'b00};
        mem_wdata <= in_op2;
      end

      if (retire) begin
        if (in_ready) begin
          IsWb       <= in_is_wb;
          IsCall     <= in_is_call;
          IsLd       <= in_is_ld;
          Rd         <= in_rd;
          AluResult1 <= in_alu;
          LdResult   <= '0;
          pc_current <= in_pc;
        end else begin
          IsWb       <= cap_wb & ~timeout;
          IsCall     <= cap_call;
          IsLd       <= cap_ld;
          Rd         <= cap_rd;
          AluResult1 <= cap_alu;
          LdResult   <= (cap_ld && mem_ack) ? mem_rdata : '0;
          pc_current <= cap_pc;
          mem_we     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: directed vector table, randomized
// transactions against a transaction-level model, and multi-cycle corner cases.
module tb_ma_stage;
  import risc_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu, in_op2;
  logic [3:0]  in_rd;
  logic        in_is_ld, in_is_st, in_is_wb, in_is_call;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        IsWb, IsCall, IsLd;
  logic [3:0]  Rd;
  logic [31:0] AluResult1, LdResult, pc_current;

  always #5 clk = ~clk;

  ma_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_op2(in_op2), .in_rd(in_rd),
    .in_is_ld(in_is_ld), .in_is_st(in_is_st), .in_is_wb(in_is_wb), .in_is_call(in_is_call),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .IsWb(IsWb), .IsCall(IsCall), .IsLd(IsLd), .Rd(Rd),
    .AluResult1(AluResult1), .LdResult(LdResult), .pc_current(pc_current)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc, alu, op2, rdata;
    logic [3:0]  rd;
    logic        ld, st, wb, call;
    int          ack_delay;   // cycles of mem_req before ack; >= TO means never
    logic        exp_wb;
    logic [31:0] exp_ldres, exp_addr;
    logic        exp_we, exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] pc, alu, op2, rdata, input logic [3:0] rd,
                              input logic ld, st, wb, call, input int dly,
                              input logic ewb, input logic [31:0] eld, eaddr,
                              input logic ewe, eerr);
    vec_t v;
    v.pc = pc; v.alu = alu; v.op2 = op2; v.rdata = rdata; v.rd = rd;
    v.ld = ld; v.st = st; v.wb = wb; v.call = call; v.ack_delay = dly;
    v.exp_wb = ewb; v.exp_ldres = eld; v.exp_addr = eaddr; v.exp_we = ewe; v.exp_err = eerr;
    return v;
  endfunction

  // Transaction-level reference: what WB must see once the instruction retires.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic is_mem = v.ld | v.st;
    logic lost   = is_mem && (v.ack_delay >= TO);
    r.exp_wb    = v.wb & ~lost;
    r.exp_ldres = (v.ld && !lost) ? v.rdata : 32'h0;
    r.exp_addr  = v.alu & 32'hFFFF_FFFC;
    r.exp_we    = v.st & ~v.ld;
    r.exp_err   = lost;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_pc = v.pc; in_alu = v.alu; in_op2 = v.op2; in_rd = v.rd;
    in_is_ld = v.ld; in_is_st = v.st; in_is_wb = v.wb; in_is_call = v.call;
  endtask

  task automatic scramble;
    in_valid = 1'b0;
    in_pc = $urandom; in_alu = $urandom; in_op2 = $urandom; in_rd = 4'($urandom);
    in_is_ld = 1'($urandom); in_is_st = 1'($urandom);
    in_is_wb = 1'($urandom); in_is_call = 1'($urandom);
  endtask

  task automatic check_retired(input string t, input vec_t v);
    check({t, ".IsWb"},   32'(IsWb),   32'(v.exp_wb));
    check({t, ".IsLd"},   32'(IsLd),   32'(v.ld));
    check({t, ".IsCall"}, 32'(IsCall), 32'(v.call));
    check({t, ".Rd"},     32'(Rd),     32'(v.rd));
    check({t, ".alu"},    AluResult1,  v.alu);
    check({t, ".pc"},     pc_current,  v.pc);
    check({t, ".ldres"},  LdResult,    v.exp_ldres);
  endtask

  task automatic run_vec(input string t, input vec_t v);
    logic done;
    check({t, ".ready_in"}, 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    step;
    scramble;
    if (!(v.ld | v.st)) begin
      check_retired(t, v);
      check({t, ".no_req"}, 32'(mem_req), 32'd0);
      step;
      check({t, ".wb_drop"}, 32'(IsWb), 32'd0);
      check({t, ".alu_hold"}, AluResult1, v.alu);
    end else begin
      check({t, ".req"},   32'(mem_req),  32'd1);
      check({t, ".we"},    32'(mem_we),   32'(v.exp_we));
      check({t, ".addr"},  mem_addr,      v.exp_addr);
      if (v.exp_we) check({t, ".wdata"}, mem_wdata, v.op2);
      check({t, ".busy"},  32'(in_ready), 32'd0);
      check({t, ".wb0"},   32'(IsWb),     32'd0);
      done = 1'b0;
      for (int k = 0; !done; k++) begin
        mem_ack   = (k == v.ack_delay);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        step;
        mem_ack = 1'b0;
        if (k == v.ack_delay || k == TO - 1) done = 1'b1;
        else begin
          check({t, ".req_hold"},  32'(mem_req),  32'd1);
          check({t, ".addr_hold"}, mem_addr,      v.exp_addr);
          check({t, ".busy_hold"}, 32'(in_ready), 32'd0);
          check({t, ".wb_wait"},   32'(IsWb),     32'd0);
        end
      end
      check_retired(t, v);
      check({t, ".req_drop"}, 32'(mem_req),  32'd0);
      check({t, ".err"},      32'(mem_err),  32'(v.exp_err));
      check({t, ".ready"},    32'(in_ready), 32'd1);
      step;
      check({t, ".err_pulse"}, 32'(mem_err), 32'd0);
      check({t, ".wb_drop"},   32'(IsWb),    32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v, a, b;

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    scramble;
    step; step;
    rst_n = 1'b1;
    check("reset.ready", 32'(in_ready), 32'd1);
    check("reset.req",   32'(mem_req),  32'd0);
    check("reset.err",   32'(mem_err),  32'd0);
    check("reset.IsWb",  32'(IsWb),     32'd0);
    check("reset.alu",   AluResult1,    32'h0);
    check("reset.addr",  mem_addr,      32'h0);

    //         pc            alu           op2           rdata         rd  ld st wb cl dly  ewb eld           eaddr         ewe eerr
    tbl.push_back(mk(32'h100, 32'h0000_1234, 32'h0,       32'h0,        3, 0, 0, 1, 0, 0,  1, 32'h0,        32'h0,        0, 0)); // ALU op
    tbl.push_back(mk(32'h104, 32'h0000_0103, 32'h0,       32'hDEAD_BEEF, 5, 1, 0, 1, 0, 3,  1, 32'hDEAD_BEEF, 32'h0000_0100, 0, 0)); // load, last-cycle ack
    tbl.push_back(mk(32'h108, 32'h0000_2008, 32'hA5A5_A5A5, 32'h0,      7, 0, 1, 0, 0, 0,  0, 32'h0,        32'h0000_2008, 1, 0)); // store, same-cycle ack
    tbl.push_back(mk(32'h10C, 32'h0000_3000, 32'h0,       32'h1111_2222, 9, 1, 0, 1, 0, 99, 0, 32'h0,        32'h0000_3000, 0, 1)); // load timeout
    tbl.push_back(mk(32'h040, 32'h0000_0000, 32'h0,       32'h0,       15, 0, 0, 1, 1, 0,  1, 32'h0,        32'h0,        0, 0)); // call
    tbl.push_back(mk(32'h110, 32'h0000_0046, 32'h5555_0000, 32'h1234_5678, 2, 1, 1, 1, 0, 1,  1, 32'h1234_5678, 32'h0000_0044, 0, 0)); // ld+st: load wins
    tbl.push_back(mk(32'h114, 32'h0000_4004, 32'hCAFE_F00D, 32'h0,     4, 0, 1, 1, 0, 5,  0, 32'h0,        32'h0000_4004, 1, 1)); // store timeout
    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Late ack after a timeout lands in IDLE and must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step;
    mem_ack = 1'b0;
    check("late_ack.IsWb",  32'(IsWb),     32'd0);
    check("late_ack.req",   32'(mem_req),  32'd0);
    check("late_ack.ready", 32'(in_ready), 32'd1);
    check("late_ack.ldres", LdResult,      32'h0);

    // Back-to-back non-memory ops retire one per cycle.
    a = mk(32'h200, 32'hAAAA_0001, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    b = mk(32'h204, 32'hBBBB_0002, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(a); in_valid = 1'b1;
    step;
    check_retired("b2b_a", a);
    drive(b);
    step;
    check_retired("b2b_b", b);
    scramble;
    step;
    check("b2b.wb_drop", 32'(IsWb), 32'd0);

    // Reset in the middle of WAIT abandons the access.
    v = mk(32'h300, 32'h0000_0500, 0, 32'h7777_7777, 6, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    drive(v); in_valid = 1'b1;
    step;
    scramble;
    step;
    check("rst_wait.req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    check("rst_wait.req0",  32'(mem_req),  32'd0);
    check("rst_wait.ready", 32'(in_ready), 32'd1);
    check("rst_wait.Rd",    32'(Rd),       32'd0);
    check("rst_wait.pc",    pc_current,    32'h0);
    check("rst_wait.addr",  mem_addr,      32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step;
    mem_ack = 1'b0;
    check("rst_ack.IsWb",  32'(IsWb),    32'd0);
    check("rst_ack.ldres", LdResult,     32'h0);
    check("rst_ack.err",   32'(mem_err), 32'd0);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom, $urandom, $urandom, $urandom, 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, TO + 1)), 0, 0, 0, 0, 0);
      run_vec($sformatf("rnd%0d", i), model(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
